// File: rtl/cond_sync_fifo.sv
// cond_sync_fifo: single-clock FIFO with a valid/ready handshake on both sides.
// Show-ahead read: the head entry sits on o_pop_data whenever o_pop_valid is high.
// Define FIFO_LEVEL_EN to add parameter AF_LEVEL and ports o_level/o_almost_full.
module cond_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
`ifdef FIFO_LEVEL_EN
    ,
    parameter int AF_LEVEL = 3
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_data
`ifdef FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_almost_full
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    // Pointer increment with wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // Handshake flags are decoded from count alone, so no input-to-output path exists.
    always_comb begin
        o_push_ready = (count != FULL_CNT);
        o_pop_valid  = (count != '0);
        push         = i_push_valid & o_push_ready;
        pop          = i_pop_ready & o_pop_valid;
        o_pop_data   = mem[rd_ptr];
    end

    // Control state: pointers and occupancy; async reset discards all contents.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data-only and deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

`ifdef FIFO_LEVEL_EN
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);

    // Occupancy outputs mirror the count register directly.
    always_comb begin
        o_level       = count;
        o_almost_full = (count >= AF_CNT);
    end
`endif

endmodule

// File: tb/tb_cond_sync_fifo.sv
// Testbench for cond_sync_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3).
// Builds with or without FIFO_LEVEL_EN; level checks are compiled in only with it.
// Reference model: a plain queue holding the words the FIFO should contain.
module tb_cond_sync_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;

    logic             i_clk;
    logic             i_rst;
    logic             i_push_valid;
    logic             o_push_ready;
    logic [WIDTH-1:0] i_push_data;
    logic             o_pop_valid;
    logic             i_pop_ready;
    logic [WIDTH-1:0] o_pop_data;
`ifdef FIFO_LEVEL_EN
    logic [2:0]       o_level;
    logic             o_almost_full;
`endif

    int n_cmp;
    int n_bad;

    logic [WIDTH-1:0] model_q[$];

    cond_sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
`ifdef FIFO_LEVEL_EN
        ,
        .AF_LEVEL(AF_LEVEL)
`endif
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push_valid (i_push_valid),
        .o_push_ready (o_push_ready),
        .i_push_data  (i_push_data),
        .o_pop_valid  (o_pop_valid),
        .i_pop_ready  (i_pop_ready),
        .o_pop_data   (o_pop_data)
`ifdef FIFO_LEVEL_EN
        ,
        .o_level      (o_level),
        .o_almost_full(o_almost_full)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Apply one cycle of stimulus and advance the queue model by the handshake rules.
    task automatic cycle(input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
        bit pf;
        bit qf;
        logic [WIDTH-1:0] dropped;
        i_push_valid = pv;
        i_push_data  = pd;
        i_pop_ready  = pr;
        pf = pv && (model_q.size() < DEPTH);
        qf = pr && (model_q.size() > 0);
        @(posedge i_clk);
        if (!i_rst) begin
            model_q.delete();
        end else begin
            if (qf) dropped = model_q.pop_front();
            if (pf) model_q.push_back(pd);
        end
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h99, 1'b0);
            n_cmp++;
            if (o_push_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready: got %b want 1", o_push_ready);
            end
            n_cmp++;
            if (o_pop_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_valid: got %b want 0", o_pop_valid);
            end
`ifdef FIFO_LEVEL_EN
            n_cmp++;
            if (o_level !== 3'd0 || o_almost_full !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_level: got %0d/%b want 0/0", o_level, o_almost_full);
            end
`endif
        end
        i_push_valid = 1'b0;
        i_rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (o_pop_valid !== 1'b0 || o_push_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: got valid=%b ready=%b want 0/1", o_pop_valid, o_push_ready);
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, words[i], 1'b0);
`ifdef FIFO_LEVEL_EN
            n_cmp++;
            if (o_level !== 3'(i + 1) || o_almost_full !== ((i + 1) >= AF_LEVEL)) begin
                n_bad++;
                $display("FAIL fill_level[%0d]: got %0d/%b want %0d/%b", i, o_level,
                         o_almost_full, i + 1, ((i + 1) >= AF_LEVEL));
            end
`endif
            n_cmp++;
            if (o_push_ready !== (i < 3)) begin
                n_bad++;
                $display("FAIL fill_ready[%0d]: got %b want %b", i, o_push_ready, (i < 3));
            end
        end
    endtask

    task automatic test_overflow_drain();
        logic [WIDTH-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        cycle(1'b1, 8'h55, 1'b0);
        n_cmp++;
        if (o_push_ready !== 1'b0 || o_pop_data !== 8'h11) begin
            n_bad++;
            $display("FAIL overflow: got ready=%b head=%h want 0/11", o_push_ready, o_pop_data);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_pop_valid !== 1'b1 || o_pop_data !== words[i]) begin
                n_bad++;
                $display("FAIL drain[%0d]: got %b/%h want 1/%h", i, o_pop_valid, o_pop_data, words[i]);
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
        n_cmp++;
        if (o_pop_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: got valid=%b want 0", o_pop_valid);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 8'h5E, 1'b0);
        cycle(1'b1, 8'h5F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (o_pop_valid !== 1'b1 || o_pop_data !== 8'(8'h5E + i)) begin
                n_bad++;
                $display("FAIL wrap_data[%0d]: got %b/%h want 1/%h", i, o_pop_valid, o_pop_data,
                         8'(8'h5E + i));
            end
            cycle(1'b1, 8'(8'h60 + i), 1'b1);
`ifdef FIFO_LEVEL_EN
            n_cmp++;
            if (o_level !== 3'd2) begin
                n_bad++;
                $display("FAIL wrap_level[%0d]: got %0d want 2", i, o_level);
            end
`endif
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (o_pop_data !== 8'(8'h68 + i)) begin
                n_bad++;
                $display("FAIL wrap_tail[%0d]: got %h want %h", i, o_pop_data, 8'(8'h68 + i));
            end
            cycle(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_empty_latency();
        i_push_valid = 1'b1;
        i_push_data  = 8'hA5;
        #2;
        n_cmp++;
        if (o_pop_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_same_cycle: got valid=%b want 0", o_pop_valid);
        end
        cycle(1'b1, 8'hA5, 1'b0);
        n_cmp++;
        if (o_pop_valid !== 1'b1 || o_pop_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL latency_next_cycle: got %b/%h want 1/a5", o_pop_valid, o_pop_data);
        end
        cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        #2;
        i_rst = 1'b0;
        model_q.delete();
        #1;
        n_cmp++;
        if (o_pop_valid !== 1'b0 || o_push_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_async: got valid=%b ready=%b want 0/1", o_pop_valid, o_push_ready);
        end
        cycle(1'b0, 8'h00, 1'b0);
        i_rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (o_pop_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_after: got valid=%b want 0", o_pop_valid);
        end
`ifdef FIFO_LEVEL_EN
        n_cmp++;
        if (o_level !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid_level: got %0d want 0", o_level);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic pv;
            logic pr;
            logic [WIDTH-1:0] pd;
            pv = 1'($urandom_range(0, 1));
            pr = 1'($urandom_range(0, 1));
            pd = 8'($urandom);
            cycle(pv, pd, pr);
            n_cmp++;
            if (o_push_ready !== (model_q.size() < DEPTH) || o_pop_valid !== (model_q.size() > 0)) begin
                n_bad++;
                $display("FAIL rand_flags[%0d]: got ready=%b valid=%b want size %0d", i,
                         o_push_ready, o_pop_valid, model_q.size());
            end
            if (model_q.size() > 0) begin
                n_cmp++;
                if (o_pop_data !== model_q[0]) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, o_pop_data, model_q[0]);
                end
            end
`ifdef FIFO_LEVEL_EN
            n_cmp++;
            if (o_level !== 3'(model_q.size()) || o_almost_full !== (model_q.size() >= AF_LEVEL)) begin
                n_bad++;
                $display("FAIL rand_level[%0d]: got %0d/%b want %0d", i, o_level, o_almost_full,
                         model_q.size());
            end
`endif
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        i_rst = 1'b0;
        i_push_valid = 1'b0;
        i_push_data  = '0;
        i_pop_ready  = 1'b0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_wrap();
        test_empty_latency();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
